// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART TX arbiter: frame layout and default sizing.
// The TX FIFO counter width falls back to 5 bits when not set by the build.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package uart_tx_arbiter_pkg;

    localparam int TXARB_FIFO_DEPTH = 16;
    localparam int TXARB_FRAME_LEN  = 8;
    localparam int TXARB_PUSH_GAP   = 4;

    localparam logic [7:0] FRAME_HEAD0 = 8'hEB;
    localparam logic [7:0] FRAME_HEAD1 = 8'h90;
    localparam logic [7:0] FRAME_TAIL0 = 8'h09;
    localparam logic [7:0] FRAME_TAIL1 = 8'hD7;

    typedef logic [1:0] src_vec_t;

endpackage

// File: rtl/txarb_rr_pick.sv
// Two-way round-robin winner: the sole requester, or the prio side on a tie.
// prio=0 favours source 0, prio=1 favours source 1.
module txarb_rr_pick
    import uart_tx_arbiter_pkg::*;
(
    input  src_vec_t req,
    input  logic     prio,
    output src_vec_t pick
);

    always_comb begin
        pick = 2'b00;
        unique case (1'b1)
            (req == 2'b11): pick = prio ? 2'b10 : 2'b01;
            (req == 2'b01): pick = 2'b01;
            (req == 2'b10): pick = 2'b10;
            default:        pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding the shared UART TX FIFO.
// Define TXARB_ABORT_EN to let a source abandon its frame by dropping req.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = TXARB_FIFO_DEPTH,
    parameter int FRAME_LEN  = TXARB_FRAME_LEN,
    parameter int PUSH_GAP   = TXARB_PUSH_GAP
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      req,
    input  logic [7:0]                      din0,
    input  logic [7:0]                      din1,
    input  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter,
    output logic [1:0]                      gnt,
    output logic [1:0]                      byte_ack,
    output logic [7:0]                      tdr,
    output logic                            tf_push,
    output logic                            busy,
    output logic                            abort
);

    localparam int CW = `UART_FIFO_COUNTER_W;
    localparam logic [CW-1:0] ROOM   = CW'(FIFO_DEPTH - FRAME_LEN);
    localparam logic [3:0]    LAST_B = 4'(FRAME_LEN);
    localparam logic [3:0]    GAP_END = 4'(PUSH_GAP - 2);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        PUSH    = 4'b0010,
        GAP     = 4'b0100,
        RELEASE = 4'b1000
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] ack_q, ack_d;
    logic [7:0] tdr_q, tdr_d;
    logic       push_q, push_d;
    logic       busy_q, busy_d;
    logic       abort_q, abort_d;
    logic       prio_q, prio_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    src_vec_t   pick;
    logic       sel;
    logic       room;
    logic       quit;

    txarb_rr_pick u_pick (
        .req  (req),
        .prio (prio_q),
        .pick (pick)
    );

    assign sel  = gnt_q[1];
    assign room = (tf_counter <= ROOM);

`ifdef TXARB_ABORT_EN
    logic pend_q, pend_d;

    // A drop anywhere in the frame is remembered until the current gap ends.
    always_comb begin
        pend_d = pend_q;
        if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else if (busy_q && !req[sel]) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign quit = pend_d;
`else
    assign quit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = 2'b00;
        tdr_d      = tdr_q;
        push_d     = 1'b0;
        busy_d     = busy_q;
        abort_d    = 1'b0;
        prio_d     = prio_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick != 2'b00 && room) begin
                    gnt_d      = pick;
                    busy_d     = 1'b1;
                    byte_cnt_d = 4'd0;
                    state_d    = PUSH;
                end
            end
            PUSH: begin
                tdr_d      = sel ? din1 : din0;
                push_d     = 1'b1;
                ack_d      = gnt_q;
                byte_cnt_d = byte_cnt_q + 4'd1;
                gap_cnt_d  = 4'd0;
                state_d    = GAP;
            end
            GAP: begin
                if (gap_cnt_q >= GAP_END) begin
                    if (byte_cnt_q == LAST_B) begin
                        state_d = RELEASE;
                    end else if (quit) begin
                        state_d = RELEASE;
                        abort_d = 1'b1;
                    end else begin
                        state_d = PUSH;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            RELEASE: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                prio_d  = ~sel;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            tdr_q      <= 8'h00;
            push_q     <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            prio_q     <= 1'b0;
            byte_cnt_q <= 4'd0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            tdr_q      <= tdr_d;
            push_q     <= push_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            prio_q     <= prio_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign byte_ack = ack_q;
    assign tdr      = tdr_q;
    assign tf_push  = push_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-schedule reference model plus directed cases.
// Abort cases are included when TXARB_ABORT_EN is defined.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int L  = TXARB_FRAME_LEN;
    localparam int G  = TXARB_PUSH_GAP;
    localparam int FD = TXARB_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [`UART_FIFO_COUNTER_W-1:0] tf_counter = '0;
    logic [1:0] gnt, byte_ack;
    logic [7:0] tdr;
    logic tf_push, busy, abort;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .tf_counter (tf_counter),
        .gnt        (gnt),
        .byte_ack   (byte_ack),
        .tdr        (tdr),
        .tf_push    (tf_push),
        .busy       (busy),
        .abort      (abort)
    );

    // Reference model: one frame is a window of cycles [t0, rel] with
    // pushes at t0+1+k*G for k < nb.
    int cyc = 0;
    bit act = 0;
    int w = 0, t0 = 0, rel = 0, nb = 0, fnum = 0;
    bit ab = 0;
    bit prio = 0;
    logic [7:0] tdr_m = 8'h00;
    int idx[2] = '{0, 0};
    int fcnt[2] = '{0, 0};
    int done[2] = '{0, 0};
    int acks[2] = '{0, 0};
    bit auto_drop[2] = '{0, 0};
    bit rand_mode = 0;

    int push_cyc[$];
    logic [7:0] push_val[$];
    logic [1:0] gnt_seq[$];
    int rise_cyc[$];
    int fall_cyc[$];
    int aborts = 0;
    logic [1:0] gnt_prev = 2'b00;

    function automatic logic [7:0] fbyte(int s, int f, int k);
        if (k == 0) return FRAME_HEAD0;
        if (k == 1) return FRAME_HEAD1;
        if (k == L - 2) return FRAME_TAIL0;
        if (k == L - 1) return FRAME_TAIL1;
        return {s[0], f[2:0], k[3:0]};
    endfunction

    task automatic chk(string name, int got, int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp_v, cyc);
        end
    endtask

    task automatic drive_din();
        din0 = fbyte(0, fcnt[0], idx[0]);
        din1 = fbyte(1, fcnt[1], idx[1]);
    endtask

    task automatic clear_logs();
        push_cyc.delete();
        push_val.delete();
        gnt_seq.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        aborts = 0;
    endtask

    task automatic neg_phase();
        logic [1:0] eg, ea;
        bit ep, eab;
        int k;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_ack", byte_ack, 0);
            chk("rst_tdr", tdr, 0);
            chk("rst_push", tf_push, 0);
            chk("rst_busy", busy, 0);
            chk("rst_abort", abort, 0);
            act = 0;
            ab = 0;
            prio = 0;
            tdr_m = 8'h00;
            gnt_prev = 2'b00;
            for (int s = 0; s < 2; s++) begin
                if (idx[s] != 0) begin
                    idx[s] = 0;
                    fcnt[s]++;
                end
            end
            drive_din();
            cyc++;
            return;
        end
        eg = 2'b00;
        ea = 2'b00;
        ep = 0;
        eab = 0;
        if (act && cyc >= t0 && cyc <= rel) eg = (w != 0) ? 2'b10 : 2'b01;
        if (act && cyc > t0 && (cyc - t0 - 1) % G == 0 &&
            (cyc - t0 - 1) / G < nb) begin
            ep = 1;
            ea = eg;
            tdr_m = fbyte(w, fnum, (cyc - t0 - 1) / G);
        end
        if (act && ab && cyc == rel) eab = 1;
        chk("gnt", gnt, eg);
        chk("busy", busy, int'(eg != 2'b00));
        chk("tf_push", tf_push, ep);
        chk("byte_ack", byte_ack, ea);
        chk("tdr", tdr, tdr_m);
        chk("abort", abort, eab);

        if (tf_push) begin
            push_cyc.push_back(cyc);
            push_val.push_back(tdr);
        end
        if (abort) aborts++;
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            rise_cyc.push_back(cyc);
            gnt_seq.push_back(gnt);
        end
        if (gnt == 2'b00 && gnt_prev != 2'b00) fall_cyc.push_back(cyc);
        gnt_prev = gnt;

        // Sources: advance on ack, restart after an abandoned frame.
        for (int s = 0; s < 2; s++) begin
            if (byte_ack[s]) begin
                acks[s]++;
                idx[s]++;
                if (idx[s] == L) begin
                    idx[s] = 0;
                    fcnt[s]++;
                    done[s]++;
                    if (auto_drop[s] || (rand_mode && $urandom_range(0, 1) == 0))
                        req[s] = 1'b0;
                end
            end else if (!req[s] && !gnt[s] && idx[s] != 0) begin
                idx[s] = 0;
                fcnt[s]++;
            end
        end
        drive_din();

`ifdef TXARB_ABORT_EN
        if (act && !ab && cyc >= t0 && cyc < rel && !req[w]) begin
            k = (cyc - t0) / G;
            if (k + 1 < L) begin
                nb = k + 1;
                rel = t0 + nb * G;
                ab = 1;
            end
        end
`else
        k = 0;
`endif

        if (act && cyc == rel) begin
            act = 0;
        end else if (!act && req != 2'b00 && int'(tf_counter) <= FD - L) begin
            w = (req == 2'b11) ? int'(prio) : (req[1] ? 1 : 0);
            act = 1;
            t0 = cyc + 1;
            nb = L;
            rel = t0 + L * G;
            ab = 0;
            fnum = fcnt[w];
            prio = (w == 0);
        end
        cyc++;
    endtask

    task automatic pos_phase();
        @(posedge clk);
        #1;
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            neg_phase();
            pos_phase();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        step(2);
        rst_n = 1'b1;
    endtask

    int cx;
    bit hit;

    initial begin
        drive_din();
        step(3);
        rst_n = 1'b1;

        // 1: single source, full frame
        clear_logs();
        auto_drop = '{1, 1};
        cx = cyc;
        req = 2'b01;
        step(45);
        chk("t1_pushes", push_cyc.size(), 8);
        if (push_cyc.size() == 8 && rise_cyc.size() > 0 && fall_cyc.size() > 0) begin
            chk("t1_first_lat", push_cyc[0] - cx, 2);
            chk("t1_gap", push_cyc[1] - push_cyc[0], 4);
            chk("t1_span", push_cyc[7] - push_cyc[0], 28);
            chk("t1_b0", push_val[0], 8'hEB);
            chk("t1_b1", push_val[1], 8'h90);
            chk("t1_b6", push_val[6], 8'h09);
            chk("t1_b7", push_val[7], 8'hD7);
            chk("t1_gnt_len", fall_cyc[0] - rise_cyc[0], 33);
        end

        // 2/3: both requesting from reset, alternate grants
        do_reset();
        clear_logs();
        auto_drop = '{0, 0};
        req = 2'b11;
        step(140);
        chk("t2_frames", int'(gnt_seq.size() >= 4), 1);
        if (gnt_seq.size() >= 4 && fall_cyc.size() >= 1) begin
            chk("t2_first", gnt_seq[0], 2'b01);
            chk("t2_second", gnt_seq[1], 2'b10);
            chk("t2_dead", rise_cyc[1] - fall_cyc[0], 1);
            chk("t3_third", gnt_seq[2], 2'b01);
            chk("t3_fourth", gnt_seq[3], 2'b10);
        end
        auto_drop = '{1, 1};
        step(80);

        // 4: room check at frame start
        clear_logs();
        tf_counter = 9;
        req = 2'b01;
        step(6);
        chk("t4_nogrant", rise_cyc.size(), 0);
        chk("t4_nopush", push_cyc.size(), 0);
        tf_counter = 8;
        cx = cyc;
        step(3);
        if (rise_cyc.size() > 0 && push_cyc.size() > 0) begin
            chk("t4_gnt_lat", rise_cyc[0] - cx, 1);
            chk("t4_push_lat", push_cyc[0] - cx, 2);
        end else begin
            chk("t4_granted", 0, 1);
        end
        step(40);
        tf_counter = 0;

        // 5: reset in the middle of a frame
        clear_logs();
        req = 2'b01;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            neg_phase();
            if (push_cyc.size() == 3) hit = 1;
            else pos_phase();
        end
        chk("t5_reach", hit, 1);
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk("t5_push", tf_push, 0);
        chk("t5_gnt", gnt, 0);
        chk("t5_busy", busy, 0);
        pos_phase();
        step(2);
        rst_n = 1'b1;
        clear_logs();
        req = 2'b10;
        step(45);
        chk("t5_pushes", push_cyc.size(), 8);
        if (push_cyc.size() == 8 && gnt_seq.size() > 0) begin
            chk("t5_src", gnt_seq[0], 2'b10);
            chk("t5_b0", push_val[0], 8'hEB);
            chk("t5_b7", push_val[7], 8'hD7);
        end

`ifdef TXARB_ABORT_EN
        // 6: source drops req mid-frame
        do_reset();
        clear_logs();
        auto_drop = '{0, 0};
        cx = acks[0];
        req = 2'b01;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1);
            if (acks[0] - cx == 2) hit = 1;
        end
        chk("t6_reach", hit, 1);
        req[0] = 1'b0;
        step(30);
        chk("t6_pushes", push_cyc.size(), 2);
        chk("t6_aborts", aborts, 1);
        chk("t6_gnt", gnt, 0);
        auto_drop = '{1, 1};
`endif

        // Randomized traffic against the model
        do_reset();
        rand_mode = 1;
        auto_drop = '{0, 0};
        for (int i = 0; i < 3000; i++) begin
            step(1);
            for (int s = 0; s < 2; s++) begin
                if (!req[s] && $urandom_range(0, 3) == 0) req[s] = 1'b1;
`ifdef TXARB_ABORT_EN
                else if (req[s] && $urandom_range(0, 63) == 0) req[s] = 1'b0;
`endif
            end
            if ($urandom_range(0, 7) == 0) tf_counter = $urandom_range(0, 10);
        end
        rand_mode = 0;
        auto_drop = '{1, 1};
        tf_counter = 0;
        step(100);
        chk("drain_idle", gnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
